ddr_read_buffer: RTL and testbench
==================================

// Module: ddr_read_buffer
// PURPOSE
//  Read-side counterpart of the DDR write buffer. Accepts one 128-bit line from the DDR controller.
//  Streams the line to the cache/CPU side as eight 16-bit words over a valid/ready handshake.
//  Sits between the DDR read-data path and the word-wide refill port of the memory hierarchy.
// PARAMETERS
//  WORD_W  16  width of one output word
//  WORDS   8   words per line; must be a power of 2; index width IW = $clog2(WORDS)
//  LINE_W  WORD_W*WORDS  line width (derived; do not override)
// PORTS
//  clk         in   1       single clock; all state updates on posedge
//  reset       in   1       synchronous, active-high
//  flush       in   1       synchronous abort of the current line
//  line_data   in   LINE_W  DDR line; word k = line_data[k*WORD_W +: WORD_W]
//  line_valid  in   1       line_data is valid
//  line_ready  out  1       buffer can accept a line this cycle
//  start_word  in   IW      first word to emit; sampled with the line
//  word_data   out  WORD_W  current word
//  word_idx    out  IW      index of word_data within the line
//  word_last   out  1       current word is the 8th (final) word of the line
//  word_valid  out  1       word_data/word_idx/word_last are valid
//  word_ready  in   1       consumer accepts the word this cycle
// BEHAVIOUR
//  - Reset: state=IDLE, buffer=0, ptr=0, cnt=0. Outputs: word_valid=0, word_data=0, word_idx=0, word_last=0.
//  - line_ready=0 while reset is high.
//  - Priority: reset > flush > handshakes.
//  - FSM states:
//    - IDLE: line_ready=1, word_valid=0.
//    - STREAM: word_valid=1.
//  - Line accept (line_valid & line_ready): buffer<=line_data, ptr<=start_word, cnt<=0, state<=STREAM.
//  - Latency: line accepted in cycle N; first word valid in cycle N+1. Words leave at 1 per cycle under word_ready=1.
//  - In STREAM: word_data=buffer[ptr], word_idx=ptr, word_last=(cnt==WORDS-1).
//  - Word handshake (word_valid & word_ready): ptr<=ptr+1 mod WORDS (wraps 7->0), cnt<=cnt+1.
//  - Outputs hold stable while word_valid & !word_ready.
//  - line_ready = IDLE | (STREAM & word_last & word_ready); combinational path from word_ready.
//  - Last handshake without a new line: state<=IDLE.
//  - Last handshake together with a new line: capture the new line, stay in STREAM, reload ptr/cnt.
//    Gives back-to-back lines with no bubble: 8 words per 8 cycles.
//  - flush: state<=IDLE, word_valid=0 next cycle, ptr/cnt<=0, buffer retained.
//    A line_valid in the same cycle as flush is not accepted (line_ready forced 0 while flush=1).
//  - Reset mid-stream: remaining words are dropped; no partial output.
//  - No line is ever emitted with fewer or more than WORDS beats except via flush or reset.
// CONFIGURATION
//  DDR_RDBUF_CWF_EN defined: critical-word-first; the stream starts at start_word and wraps through all WORDS.
//  Not defined: start_word ignored; ptr loads 0 and words always emit in order 0..WORDS-1.
//  word_last and the beat count are identical in both modes.
// STRUCTURE
//  Package ddr_buf_pkg holds:
//   - WORD_W, WORDS, LINE_W, IW constants (shared with the write buffer)
//   - state enum {IDLE, STREAM}
//  Sub-module ddr_word_mux: combinational WORDS:1 select of a WORD_W slice by ptr.
//  FSM, pointer/counter and handshake logic stay in ddr_read_buffer.
// TESTING
//  1. Reset, then line 0x0007_0006_..._0000, start_word=0, word_ready=1
//     -> words 0..7 on cycles N+1..N+8; word_last only on idx 7.
//  2. CWF_EN, start_word=5 -> idx sequence 5,6,7,0,1,2,3,4; word_last on idx 4; data matches the slices.
//  3. word_ready low on beat 3 for 4 cycles -> word_data/word_idx held stable; no beat skipped or repeated.
//  4. Two lines back-to-back, line_valid high at the last beat -> 16 consecutive beats, no idle cycle,
//     line_ready=1 only on the last beat.
//  5. flush at beat 4 -> word_valid=0 next cycle; line_ready=1 in IDLE; the next line restarts at its start_word.
//  6. reset at beat 2, with line_valid high in the same cycle -> line not accepted; outputs 0; IDLE after release.

Source files
------------

// File: rtl/ddr_buf_pkg.sv
// ddr_buf_pkg -- shared constants and types for the DDR line buffers.
//   WORD_W : width of one word on the word-wide side
//   WORDS  : words per DDR line (power of two)
//   LINE_W : full line width, derived
//   IW     : width of a word index within a line
//   state_e: read-buffer FSM states
// No ports (package).
package ddr_buf_pkg;

  localparam int WORD_W = 16;
  localparam int WORDS  = 8;
  localparam int LINE_W = WORD_W * WORDS;
  localparam int IW     = $clog2(WORDS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/ddr_read_buffer_if.sv
// ddr_read_buffer_if -- line-in / word-out bus of the DDR read buffer.
//   line_data  : 128-bit DDR line, word k at [k*WORD_W +: WORD_W]
//   line_valid : line_data valid
//   line_ready : buffer accepts a line this cycle
//   start_word : first word index to emit, sampled with the line
//   word_data  : current word
//   word_idx   : index of word_data within its line
//   word_last  : final beat of the line
//   word_valid : word_* outputs valid
//   word_ready : consumer takes the word this cycle
// Modports: slave = the buffer, master = the DDR side plus the consumer.
interface ddr_read_buffer_if;
  import ddr_buf_pkg::*;

  logic [LINE_W-1:0] line_data;
  logic              line_valid;
  logic              line_ready;
  logic [IW-1:0]     start_word;
  logic [WORD_W-1:0] word_data;
  logic [IW-1:0]     word_idx;
  logic              word_last;
  logic              word_valid;
  logic              word_ready;

  modport slave (
    input  line_data, line_valid, start_word, word_ready,
    output line_ready, word_data, word_idx, word_last, word_valid
  );

  modport master (
    output line_data, line_valid, start_word, word_ready,
    input  line_ready, word_data, word_idx, word_last, word_valid
  );

endinterface

// File: rtl/ddr_word_mux.sv
// ddr_word_mux -- combinational WORDS:1 select of one WORD_W slice of a line.
//   line : full line (input)
//   sel  : word index (input)
//   word : line[sel*WORD_W +: WORD_W] (output)
module ddr_word_mux
  import ddr_buf_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [IW-1:0]     sel,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] words_s [WORDS];

  for (genvar k = 0; k < WORDS; k++) begin : g_split
    assign words_s[k] = line[k*WORD_W +: WORD_W];
  end

  assign word = words_s[sel];

endmodule

// File: rtl/ddr_read_buffer.sv
// ddr_read_buffer -- holds one DDR line and streams it out as WORDS words
// over a valid/ready handshake.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   flush : synchronous abort of the current line (buffer contents kept)
//   bus   : ddr_read_buffer_if.slave (line input, word output)
// Build option DDR_RDBUF_CWF_EN: critical-word-first, the stream starts at
// start_word and wraps; without it start_word is ignored and words leave in
// order 0..WORDS-1. The beat count and word_last are the same in both builds.
module ddr_read_buffer
  import ddr_buf_pkg::*;
(
  input logic              clk,
  input logic              reset,
  input logic              flush,
  ddr_read_buffer_if.slave bus
);

  state_e            state_r;
  state_e            state_s;
  logic [LINE_W-1:0] buffer_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     cnt_r;
  logic [IW-1:0]     load_ptr_s;
  logic [WORD_W-1:0] mux_word_s;
  logic              streaming_s;
  logic              last_s;
  logic              beat_s;
  logic              line_ready_s;
  logic              accept_s;

  ddr_word_mux u_word_mux (
    .line (buffer_r),
    .sel  (ptr_r),
    .word (mux_word_s)
  );

`ifdef DDR_RDBUF_CWF_EN
  assign load_ptr_s = bus.start_word;
`else
  logic start_unused_s;
  assign start_unused_s = ^bus.start_word;
  assign load_ptr_s     = {IW{1'b0}};
`endif

  // Handshake decode and next-state logic.
  always_comb begin
    streaming_s = (state_r == STREAM);
    // The beat counter, not the pointer, marks the end: with a wrapped
    // start the last word index is start_word-1, but the count is always WORDS.
    last_s      = streaming_s && (cnt_r == IW'(WORDS - 1));
    beat_s      = streaming_s && bus.word_ready;
    // A new line may land on the same edge as the final beat, so line_ready
    // looks straight through to word_ready to avoid a bubble between lines.
    if (reset || flush) begin
      line_ready_s = 1'b0;
    end else begin
      line_ready_s = !streaming_s || (last_s && bus.word_ready);
    end
    accept_s = bus.line_valid && line_ready_s;
    state_s  = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (beat_s && last_s && !accept_s) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output drive; word outputs are forced to zero outside STREAM.
  always_comb begin
    bus.line_ready = line_ready_s;
    bus.word_valid = streaming_s;
    if (streaming_s) begin
      bus.word_data = mux_word_s;
      bus.word_idx  = ptr_r;
      bus.word_last = last_s;
    end else begin
      bus.word_data = {WORD_W{1'b0}};
      bus.word_idx  = {IW{1'b0}};
      bus.word_last = 1'b0;
    end
  end

  // State, line buffer, word pointer and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      buffer_r <= {LINE_W{1'b0}};
      ptr_r    <= {IW{1'b0}};
      cnt_r    <= {IW{1'b0}};
    end else if (flush) begin
      state_r <= IDLE;
      ptr_r   <= {IW{1'b0}};
      cnt_r   <= {IW{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        buffer_r <= bus.line_data;
        ptr_r    <= load_ptr_s;
        cnt_r    <= {IW{1'b0}};
      end else if (beat_s) begin
        // Pointer wraps naturally at WORDS since WORDS is a power of two.
        ptr_r <= ptr_r + IW'(1);
        cnt_r <= cnt_r + IW'(1);
      end else begin
        ptr_r <= ptr_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_ddr_read_buffer.sv
// tb_ddr_read_buffer -- directed bench for ddr_read_buffer. Inputs change on
// the falling edge and outputs are checked 1 time unit later, so each check
// sees the state left by the previous rising edge.
module tb_ddr_read_buffer;
  import ddr_buf_pkg::*;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic [IW-1:0]     start;
    logic [IW-1:0]     exp_first;
    logic [WORD_W-1:0] exp_first_data;
    logic [IW-1:0]     exp_last;
  } vec_t;

  localparam logic [LINE_W-1:0] ZL = {LINE_W{1'b0}};

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  ddr_read_buffer_if bus_i ();

  ddr_read_buffer dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] slice(input logic [LINE_W-1:0] line, input logic [IW-1:0] k);
    return line[k*WORD_W +: WORD_W];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic lv, input logic [LINE_W-1:0] ld, input logic [IW-1:0] sw,
                     input logic wr, input logic fl, input logic rs);
    @(negedge clk);
    bus_i.line_valid = lv;
    bus_i.line_data  = ld;
    bus_i.start_word = sw;
    bus_i.word_ready = wr;
    flush            = fl;
    reset            = rs;
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [LINE_W-1:0] line, input logic [IW-1:0] idx,
                          input logic last, input logic lr);
    chk({tag, ".valid"}, 32'(bus_i.word_valid), 32'(1'b1));
    chk({tag, ".idx"},   32'(bus_i.word_idx),   32'(idx));
    chk({tag, ".data"},  32'(bus_i.word_data),  32'(slice(line, idx)));
    chk({tag, ".last"},  32'(bus_i.word_last),  32'(last));
    chk({tag, ".lrdy"},  32'(bus_i.line_ready), 32'(lr));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus_i.word_valid), 32'(1'b0));
    chk({tag, ".data"},  32'(bus_i.word_data),  32'(16'h0000));
    chk({tag, ".idx"},   32'(bus_i.word_idx),   32'(3'd0));
    chk({tag, ".last"},  32'(bus_i.word_last),  32'(1'b0));
    chk({tag, ".lrdy"},  32'(bus_i.line_ready), 32'(1'b1));
  endtask

  initial begin
    vec_t          vecs [3];
    logic [IW-1:0] e;

    vecs[0] = '{line: 128'h0007_0006_0005_0004_0003_0002_0001_0000, start: 3'd0,
                exp_first: 3'd0, exp_first_data: 16'h0000, exp_last: 3'd7};
`ifdef DDR_RDBUF_CWF_EN
    vecs[1] = '{line: 128'h7777_6666_5555_4444_3333_2222_1111_0000, start: 3'd5,
                exp_first: 3'd5, exp_first_data: 16'h5555, exp_last: 3'd4};
    vecs[2] = '{line: 128'hF00D_BEEF_CAFE_1234_A5A5_5A5A_FFFF_8001, start: 3'd3,
                exp_first: 3'd3, exp_first_data: 16'hA5A5, exp_last: 3'd2};
`else
    vecs[1] = '{line: 128'h7777_6666_5555_4444_3333_2222_1111_0000, start: 3'd5,
                exp_first: 3'd0, exp_first_data: 16'h0000, exp_last: 3'd7};
    vecs[2] = '{line: 128'hF00D_BEEF_CAFE_1234_A5A5_5A5A_FFFF_8001, start: 3'd3,
                exp_first: 3'd0, exp_first_data: 16'h8001, exp_last: 3'd7};
`endif

    reset            = 1'b1;
    flush            = 1'b0;
    bus_i.line_valid = 1'b0;
    bus_i.line_data  = ZL;
    bus_i.start_word = 3'd0;
    bus_i.word_ready = 1'b0;

    // Reset state: no line accepted, word outputs zero.
    cyc(1'b0, ZL, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, vecs[0].line, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("rst.lrdy",  32'(bus_i.line_ready), 32'(1'b0));
    chk("rst.valid", 32'(bus_i.word_valid), 32'(1'b0));
    chk("rst.data",  32'(bus_i.word_data),  32'(16'h0000));
    chk("rst.idx",   32'(bus_i.word_idx),   32'(3'd0));
    chk("rst.last",  32'(bus_i.word_last),  32'(1'b0));

    // Table: one full line per entry at full throughput.
    for (int v = 0; v < 3; v++) begin
      cyc(1'b1, vecs[v].line, vecs[v].start, 1'b1, 1'b0, 1'b0);
      chk("tbl.accept_lrdy", 32'(bus_i.line_ready), 32'(1'b1));
      chk("tbl.accept_valid", 32'(bus_i.word_valid), 32'(1'b0));
      for (int b = 0; b < 8; b++) begin
        cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
        e = vecs[v].exp_first + IW'(b);
        if (b == 0) chk("tbl.first_data", 32'(bus_i.word_data), 32'(vecs[v].exp_first_data));
        if (b == 7) chk("tbl.last_idx", 32'(bus_i.word_idx), 32'(vecs[v].exp_last));
        chk_beat("tbl", vecs[v].line, e, (b == 7), (b == 7));
      end
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_idle("tbl.after");
    end

    // Stall on beat 3 for 4 cycles: outputs held, nothing skipped or repeated.
    cyc(1'b1, vecs[2].line, vecs[2].start, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      e = vecs[2].exp_first + IW'(b);
      if (b == 3) begin
        for (int s = 0; s < 4; s++) begin
          cyc(1'b0, ZL, 3'd0, 1'b0, 1'b0, 1'b0);
          chk_beat("stall.hold", vecs[2].line, e, 1'b0, 1'b0);
        end
      end
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("stall", vecs[2].line, e, (b == 7), (b == 7));
    end
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("stall.after");

    // Back-to-back lines: second line offered on the last beat of the first.
    cyc(1'b1, vecs[0].line, vecs[0].start, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) cyc(1'b1, vecs[2].line, vecs[2].start, 1'b1, 1'b0, 1'b0);
      else        cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("b2b.a", vecs[0].line, vecs[0].exp_first + IW'(b), (b == 7), (b == 7));
    end
    for (int b = 0; b < 8; b++) begin
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("b2b.b", vecs[2].line, vecs[2].exp_first + IW'(b), (b == 7), (b == 7));
    end
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("b2b.after");

    // Flush on beat 4 with a line offered in the same cycle (must be refused).
    cyc(1'b1, vecs[1].line, vecs[1].start, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("fl.pre", vecs[1].line, vecs[1].exp_first + IW'(b), 1'b0, 1'b0);
    end
    cyc(1'b1, vecs[2].line, vecs[2].start, 1'b1, 1'b1, 1'b0);
    chk("fl.lrdy", 32'(bus_i.line_ready), 32'(1'b0));
    chk("fl.valid", 32'(bus_i.word_valid), 32'(1'b1));
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("fl.after");
    cyc(1'b1, vecs[2].line, vecs[2].start, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("fl.next", vecs[2].line, vecs[2].exp_first + IW'(b), (b == 7), (b == 7));
    end
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("fl.end");

    // Reset on beat 2 with line_valid high: line refused, outputs cleared.
    cyc(1'b1, vecs[0].line, vecs[0].start, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
      chk_beat("rs.pre", vecs[0].line, vecs[0].exp_first + IW'(b), 1'b0, 1'b0);
    end
    cyc(1'b1, vecs[2].line, vecs[2].start, 1'b1, 1'b0, 1'b1);
    chk("rs.lrdy", 32'(bus_i.line_ready), 32'(1'b0));
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("rs.after");
    cyc(1'b0, ZL, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_idle("rs.after2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
